// File: rtl/xreg_arb_pkg.sv
// rtl/xreg_arb_pkg.sv - shared FSM encoding and width helper for the software-access arbiter
package xreg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } xreg_state_e;

  // Also reused for the requester index width: a one-entry range still needs one bit.
  function automatic int addr_w_f(input int reg_cnt);
    return (reg_cnt > 1) ? $clog2(reg_cnt) : 1;
  endfunction

endpackage

// File: rtl/xreg_rr_arbiter.sv
// rtl/xreg_rr_arbiter.sv - round-robin requester arbiter owning the last-grant pointer
module xreg_rr_arbiter
  import xreg_arb_pkg::*;
#(
  parameter int REQ_CNT = 2,
  parameter int IDX_W   = addr_w_f(REQ_CNT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_CNT-1:0] req,
  input  logic               advance,
  output logic [REQ_CNT-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_found;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = REQ_CNT - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = IDX_W'(j);
        if (j > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    for (int j = 0; j < REQ_CNT; j++) begin
      grant[j] = req[j] && (grant_idx == IDX_W'(j));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(REQ_CNT - 1);
    end else if (advance && |req) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/xreg_sw_arbiter.sv
// rtl/xreg_sw_arbiter.sv - software access controller for a register bank; XREG_ARB_ADDR_ERR_EN enables err on out-of-range access
module xreg_sw_arbiter
  import xreg_arb_pkg::*;
#(
  parameter int REQ_CNT = 2,
  parameter int REG_CNT = 8,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = addr_w_f(REG_CNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REQ_CNT-1:0]        req,
  input  logic [REQ_CNT-1:0]        req_wr,
  input  logic [REQ_CNT*ADDR_W-1:0] req_addr,
  input  logic [REQ_CNT*DATA_W-1:0] req_wdata,
  output logic [REQ_CNT-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic [REG_CNT-1:0]        reg_sw_wr,
  output logic [REG_CNT-1:0]        reg_sw_rd,
  output logic [DATA_W-1:0]         reg_wr_data,
  input  logic [REG_CNT*DATA_W-1:0] reg_rd_data
);

  localparam int         IDX_W     = addr_w_f(REQ_CNT);
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  logic [1:0]         state_q;
  logic [REQ_CNT-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   gnt_q;
  logic               wr_q;
  logic               hit_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [REG_CNT-1:0] addr_oh;
  logic [DATA_W-1:0]  rd_sel;
  logic [REQ_CNT-1:0] ack_nxt;
  logic               advance;

  assign advance = (state_q == ST_IDLE);

  xreg_rr_arbiter #(
    .REQ_CNT (REQ_CNT),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < REQ_CNT; j++) begin
      if (grant[j]) begin
        sel_wr    = req_wr[j];
        sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
    end
    // An out-of-range index matches no register, so it naturally raises no strobe.
    for (int r = 0; r < REG_CNT; r++) begin
      addr_oh[r] = (sel_addr == ADDR_W'(r));
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int r = 0; r < REG_CNT; r++) begin
      if (addr_q == ADDR_W'(r)) rd_sel = reg_rd_data[r*DATA_W +: DATA_W];
    end
    for (int j = 0; j < REQ_CNT; j++) begin
      ack_nxt[j] = (gnt_q == IDX_W'(j));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      hit_q       <= 1'b0;
      addr_q      <= '0;
      ack         <= '0;
      rdata       <= '0;
      reg_sw_wr   <= '0;
      reg_sw_rd   <= '0;
      reg_wr_data <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q       <= grant_idx;
            wr_q        <= sel_wr;
            addr_q      <= sel_addr;
            hit_q       <= |addr_oh;
            reg_wr_data <= sel_wdata;
            reg_sw_wr   <= sel_wr ? addr_oh : '0;
            reg_sw_rd   <= sel_wr ? '0 : addr_oh;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          reg_sw_wr <= '0;
          reg_sw_rd <= '0;
          // Sampled on the same edge that applies read side effects, so the pre-clear value returns.
          rdata     <= (!wr_q && hit_q) ? rd_sel : '0;
          ack       <= ack_nxt;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          ack     <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef XREG_ARB_ADDR_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      err <= !hit_q;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xreg_sw_arbiter.sv
// tb/tb_xreg_sw_arbiter.sv - scoreboard bench for xreg_sw_arbiter with a small register-bank model
module tb_xreg_sw_arbiter;

  localparam int RQ = 2;
  localparam int RG = 9;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef XREG_ARB_ADDR_ERR_EN
  localparam logic ERR_OOR = 1'b1;
`else
  localparam logic ERR_OOR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [RQ-1:0]    req = '0;
  logic [RQ-1:0]    req_wr = '0;
  logic [RQ*AW-1:0] req_addr = '0;
  logic [RQ*DW-1:0] req_wdata = '0;
  logic [RQ-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic             err;
  logic [RG-1:0]    reg_sw_wr;
  logic [RG-1:0]    reg_sw_rd;
  logic [DW-1:0]    reg_wr_data;
  logic [RG*DW-1:0] reg_rd_data;

  xreg_sw_arbiter #(
    .REQ_CNT (RQ),
    .REG_CNT (RG),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ack         (ack),
    .rdata       (rdata),
    .err         (err),
    .reg_sw_wr   (reg_sw_wr),
    .reg_sw_rd   (reg_sw_rd),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RQ-1:0] ack;
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  typedef struct {
    logic [RG-1:0] wr;
    logic [RG-1:0] rd;
    logic [DW-1:0] wd;
  } strb_t;

  resp_t resp_q[$];
  strb_t strb_q[$];
  resp_t mon_r;
  strb_t mon_s;
  int    checks = 0;
  int    passed = 0;
  int    cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Register bank model: reg 7 is clear-on-read, all others plain read/write.
  logic [DW-1:0] mem [RG];

  function automatic logic [DW-1:0] preset(input int r);
    case (r)
      5:       return 32'h1234_5678;
      7:       return 32'h0000_00FF;
      default: return 32'h1111_1111 * r;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < RG; r++) mem[r] <= preset(r);
    end else begin
      for (int r = 0; r < RG; r++) begin
        if (reg_sw_wr[r]) mem[r] <= reg_wr_data;
        if (reg_sw_rd[r] && r == 7) mem[r] <= '0;
      end
    end
  end

  always_comb begin
    reg_rd_data = '0;
    for (int r = 0; r < RG; r++) reg_rd_data[r*DW +: DW] = mem[r];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (|ack) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          mon_r = resp_q.pop_front();
          chk("ack_port", 64'(ack), 64'(mon_r.ack));
          chk("rdata", 64'(rdata), 64'(mon_r.rdata));
          chk("err", 64'(err), 64'(mon_r.err));
        end
      end
      if (|reg_sw_wr || |reg_sw_rd) begin
        if (strb_q.size() == 0) begin
          chk("unexpected_strobe", 64'({reg_sw_wr, reg_sw_rd}), 64'd0);
        end else begin
          mon_s = strb_q.pop_front();
          chk("sw_wr", 64'(reg_sw_wr), 64'(mon_s.wr));
          chk("sw_rd", 64'(reg_sw_rd), 64'(mon_s.rd));
          chk("wr_data", 64'(reg_wr_data), 64'(mon_s.wd));
        end
      end
    end
  end

  task automatic drive(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[p]             = w;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req[p]                = 1'b1;
  endtask

  task automatic expect_acc(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] rd, input logic er);
    resp_t r;
    strb_t s;
    r.ack   = RQ'(1) << p;
    r.rdata = rd;
    r.err   = er;
    resp_q.push_back(r);
    if (int'(a) < RG) begin
      s.wr = w ? (RG'(1) << a) : '0;
      s.rd = w ? '0 : (RG'(1) << a);
      s.wd = d;
      strb_q.push_back(s);
    end
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 0;
    while (!ack[p] && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (n >= 12) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic release_req(input int p);
    @(posedge clk);
    #1 req[p] = 1'b0;
  endtask

  task automatic single(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rd, input logic er);
    int n;
    @(negedge clk);
    expect_acc(p, w, a, d, rd, er);
    drive(p, w, a, d);
    wait_ack(p, n);
    chk("latency", 64'(n), 64'd2);
    release_req(p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   k;
    int   t[4];
    strb_t s;

    repeat (2) @(negedge clk);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_sw_wr", 64'(reg_sw_wr), 64'd0);
    chk("rst_sw_rd", 64'(reg_sw_rd), 64'd0);
    chk("rst_wr_data", 64'(reg_wr_data), 64'd0);
    rst_n = 1'b1;

    single(0, 1'b1, 4'd3, 32'hA5A5_0001, 32'h0, 1'b0);
    single(0, 1'b0, 4'd5, 32'h0, 32'h1234_5678, 1'b0);
    single(1, 1'b0, 4'd3, 32'h0, 32'hA5A5_0001, 1'b0);
    single(0, 1'b0, 4'd7, 32'h0, 32'h0000_00FF, 1'b0);
    single(0, 1'b0, 4'd7, 32'h0, 32'h0, 1'b0);
    single(1, 1'b1, 4'd9, 32'hDEAD_BEEF, 32'h0, ERR_OOR);
    single(1, 1'b0, 4'd9, 32'h0, 32'h0, ERR_OOR);

    // Both requesters held: last grant was 1, so the order is 0,1,0,1.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      expect_acc(0, 1'b0, 4'd1, 32'h0, 32'h1111_1111, 1'b0);
      expect_acc(1, 1'b0, 4'd2, 32'h0, 32'h2222_2222, 1'b0);
    end
    drive(0, 1'b0, 4'd1, 32'h0);
    drive(1, 1'b0, 4'd2, 32'h0);
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (|ack) begin
        t[k] = cyc;
        k++;
      end
    end
    chk("alt_ack_count", 64'(k), 64'd4);
    for (int i = 1; i < 4; i++) chk("alt_ack_gap", 64'(t[i] - t[i-1]), 64'd3);
    @(posedge clk);
    #1 req = '0;

    // Reset while a write strobe is in flight: no write lands and no ack follows.
    @(negedge clk);
    s.wr = RG'(1) << 4;
    s.rd = '0;
    s.wd = 32'h0000_BEEF;
    strb_q.push_back(s);
    drive(1, 1'b1, 4'd4, 32'h0000_BEEF);
    n = 0;
    while (!(|reg_sw_wr) && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_before_reset", 64'(reg_sw_wr), 64'(RG'(1) << 4));
    #2 rst_n = 1'b0;
    #1;
    chk("async_sw_wr", 64'(reg_sw_wr), 64'd0);
    chk("async_sw_rd", 64'(reg_sw_rd), 64'd0);
    req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("ack_in_reset", 64'(ack), 64'd0);
    end
    rst_n = 1'b1;

    @(negedge clk);
    expect_acc(0, 1'b0, 4'd3, 32'h0, 32'h3333_3333, 1'b0);
    expect_acc(1, 1'b0, 4'd4, 32'h0, 32'h4444_4444, 1'b0);
    drive(0, 1'b0, 4'd3, 32'h0);
    drive(1, 1'b0, 4'd4, 32'h0);
    wait_ack(0, n);
    chk("post_reset_latency", 64'(n), 64'd2);
    release_req(0);
    wait_ack(1, n);
    release_req(1);

    repeat (4) @(negedge clk);
    chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);
    chk("strobe_queue_empty", 64'(strb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
